spi_seq_arbiter: RTL

//  Shares one SPI2 master core (wr/din/divider/bits/busy/dout) between NREQ requesters.

---
 rtl/spi_seq_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/spi_seq_arbiter.sv
// Round-robin arbiter that shares one SPI master core between NREQ requesters.
// Drives per-slave active-low chip selects with setup/hold spacing; supports burst lock.
module spi_seq_arbiter #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned NCS   = 4,
    parameter int unsigned CSDLY = 4
) (
    input  logic                 clk,
    input  logic                 resetb,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_hold,
    input  logic [2*NREQ-1:0]    req_cs,
    input  logic [8*NREQ-1:0]    req_div,
    input  logic [6*NREQ-1:0]    req_bits,
    input  logic [32*NREQ-1:0]   req_din,
    output logic [NREQ-1:0]      ack,
    output logic [31:0]          rdata,
    output logic [NCS-1:0]       cs_n,
    output logic                 spi_wr,
    output logic [31:0]          spi_din,
    output logic [7:0]           spi_divider,
    output logic [5:0]           spi_bits,
    input  logic                 spi_busy,
    input  logic [31:0]          spi_dout,
    output logic                 active
);

    typedef enum logic [2:0] {
        StIdle, StSetup, StStart, StWait1, StXfer, StDone, StHold, StGap
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  rr_q, gnt_q, cs_idx_q;
    logic        lock_q, hold_q;
    logic [31:0] rdata_q, spi_din_q;
    logic [7:0]  spi_div_q;
    logic [5:0]  spi_bits_q;

    logic [1:0]  win, sel, rr_next, sel_cs;
    logic        found, lock_req, take, sel_hold, cs_on;
    logic [7:0]  sel_div;
    logic [5:0]  sel_bits;
    logic [31:0] sel_din;

    // Winner search: first asserted req at or after rr_q, wrapping once.
    always_comb begin
        found    = 1'b0;
        win      = rr_q;
        lock_req = 1'b0;
        for (int unsigned i = 0; i < 2 * NREQ; i++) begin
            if (!found && i >= 32'(rr_q) && req[i % NREQ]) begin
                found = 1'b1;
                win   = 2'(i % NREQ);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_q == 2'(i)) lock_req = req[i];
        end
        take    = lock_q ? lock_req : found;
        sel     = lock_q ? gnt_q : win;
        rr_next = (32'(win) == NREQ - 1) ? 2'd0 : win + 2'd1;
        sel_cs   = '0;
        sel_div  = '0;
        sel_bits = '0;
        sel_din  = '0;
        sel_hold = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (sel == 2'(i)) begin
                sel_cs   = req_cs[2*i +: 2];
                sel_div  = req_div[8*i +: 8];
                sel_bits = req_bits[6*i +: 6];
                sel_din  = req_din[32*i +: 32];
                sel_hold = req_hold[i];
            end
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = 8'd0;
        unique case (state_q)
            StIdle:  if (take) state_d = lock_q ? StStart : StSetup;
            StSetup: begin
                if (cnt_q == 8'(CSDLY - 1)) state_d = StStart;
                else cnt_d = cnt_q + 8'd1;
            end
            // A zero-length word never reaches the core.
            StStart: state_d = (spi_bits_q == 6'd0) ? StDone : StWait1;
            StWait1: state_d = StXfer;
            StXfer:  if (!spi_busy) state_d = StDone;
            StDone:  state_d = hold_q ? StIdle : StHold;
            StHold: begin
                if (cnt_q == 8'(CSDLY - 1)) state_d = StGap;
                else cnt_d = cnt_q + 8'd1;
            end
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            rr_q       <= 2'd0;
            gnt_q      <= 2'd0;
            cs_idx_q   <= 2'd0;
            lock_q     <= 1'b0;
            hold_q     <= 1'b0;
            rdata_q    <= 32'd0;
            spi_din_q  <= 32'd0;
            spi_div_q  <= 8'd0;
            spi_bits_q <= 6'd0;
        end else begin
            if (state_q == StIdle && take) begin
                gnt_q      <= sel;
                cs_idx_q   <= sel_cs;
                hold_q     <= sel_hold;
                spi_din_q  <= sel_din;
                spi_div_q  <= sel_div;
                spi_bits_q <= (sel_bits > 6'd32) ? 6'd32 : sel_bits;
                if (!lock_q) rr_q <= rr_next;
            end
            if (state_q == StStart && spi_bits_q == 6'd0) rdata_q <= 32'd0;
            if (state_q == StXfer && !spi_busy) rdata_q <= spi_dout;
            if (state_q == StDone) lock_q <= hold_q;
        end
    end

    always_comb begin
        cs_on = (state_q != StIdle && state_q != StGap) || (state_q == StIdle && lock_q);
        for (int unsigned i = 0; i < NCS; i++) begin
            cs_n[i] = !(cs_on && cs_idx_q == 2'(i));
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            ack[i] = (state_q == StDone) && (gnt_q == 2'(i));
        end
        spi_wr      = (state_q == StStart) && (spi_bits_q != 6'd0);
        active      = (state_q != StIdle) || lock_q;
        rdata       = rdata_q;
        spi_din     = spi_din_q;
        spi_divider = spi_div_q;
        spi_bits    = spi_bits_q;
    end

endmodule
